// File: rtl/ga_issue_unit_if.sv
// ga_issue_unit_if: core instruction, coprocessor request/response and writeback bundle
interface ga_issue_unit_if #(
    parameter int MvW          = 1024,
    parameter int PerfCntWidth = 16
);
    logic                    instr_valid_i;
    logic                    instr_ready_o;
    logic [4:0]              instr_funct_i;
    logic [4:0]              instr_rd_i;
    logic [4:0]              instr_reg_a_i;
    logic [4:0]              instr_reg_b_i;
    logic                    instr_use_ga_regs_i;
    logic                    instr_we_i;
    logic [MvW-1:0]          instr_op_a_i;
    logic [MvW-1:0]          instr_op_b_i;
    logic                    flush_i;
    logic                    ga_req_valid_o;
    logic [4:0]              ga_req_funct_o;
    logic [4:0]              ga_req_rd_o;
    logic [4:0]              ga_req_reg_a_o;
    logic [4:0]              ga_req_reg_b_o;
    logic                    ga_req_we_o;
    logic                    ga_req_use_ga_regs_o;
    logic [MvW-1:0]          ga_req_op_a_o;
    logic [MvW-1:0]          ga_req_op_b_o;
    logic                    ga_resp_busy_i;
    logic                    ga_resp_valid_i;
    logic [MvW-1:0]          ga_resp_result_i;
    logic                    ga_resp_error_i;
    logic                    ga_resp_overflow_i;
    logic                    ga_resp_underflow_i;
    logic                    wb_valid_o;
    logic                    wb_ready_i;
    logic [4:0]              wb_rd_o;
    logic                    wb_we_o;
    logic [MvW-1:0]          wb_result_o;
    logic                    wb_error_o;
    logic                    wb_overflow_o;
    logic                    wb_underflow_o;
    logic                    wb_timeout_o;
    logic [PerfCntWidth-1:0] perf_issued_o;
    logic [PerfCntWidth-1:0] perf_timeouts_o;

    modport master (
        input  instr_valid_i, instr_funct_i, instr_rd_i, instr_reg_a_i, instr_reg_b_i,
               instr_use_ga_regs_i, instr_we_i, instr_op_a_i, instr_op_b_i, flush_i,
               ga_resp_busy_i, ga_resp_valid_i, ga_resp_result_i, ga_resp_error_i,
               ga_resp_overflow_i, ga_resp_underflow_i, wb_ready_i,
        output instr_ready_o, ga_req_valid_o, ga_req_funct_o, ga_req_rd_o, ga_req_reg_a_o,
               ga_req_reg_b_o, ga_req_we_o, ga_req_use_ga_regs_o, ga_req_op_a_o, ga_req_op_b_o,
               wb_valid_o, wb_rd_o, wb_we_o, wb_result_o, wb_error_o, wb_overflow_o,
               wb_underflow_o, wb_timeout_o, perf_issued_o, perf_timeouts_o
    );

    modport slave (
        output instr_valid_i, instr_funct_i, instr_rd_i, instr_reg_a_i, instr_reg_b_i,
               instr_use_ga_regs_i, instr_we_i, instr_op_a_i, instr_op_b_i, flush_i,
               ga_resp_busy_i, ga_resp_valid_i, ga_resp_result_i, ga_resp_error_i,
               ga_resp_overflow_i, ga_resp_underflow_i, wb_ready_i,
        input  instr_ready_o, ga_req_valid_o, ga_req_funct_o, ga_req_rd_o, ga_req_reg_a_o,
               ga_req_reg_b_o, ga_req_we_o, ga_req_use_ga_regs_o, ga_req_op_a_o, ga_req_op_b_o,
               wb_valid_o, wb_rd_o, wb_we_o, wb_result_o, wb_error_o, wb_overflow_o,
               wb_underflow_o, wb_timeout_o, perf_issued_o, perf_timeouts_o
    );
endinterface

// File: rtl/ga_issue_unit.sv
// ga_issue_unit: single-outstanding GA coprocessor request initiator with timeout and writeback
module ga_issue_unit #(
    parameter int DataWidth     = 32,
    parameter int NumBlades     = 32,
    parameter int TimeoutCycles = 16,
    parameter int PerfCntWidth  = 16
) (
    input logic clk_i,
    input logic rst_i,
    ga_issue_unit_if.master bus
);
    localparam int MvW  = DataWidth * NumBlades;
    localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, WB} state_e;

    state_e                  state, state_n;
    logic [CntW-1:0]         cnt;
    logic                    accept, tmo, done;
    logic [4:0]              funct, rd, reg_a, reg_b;
    logic                    we, use_ga;
    logic [MvW-1:0]          op_a, op_b, wb_result;
    logic                    wb_error, wb_overflow, wb_underflow, wb_timeout;
    logic [PerfCntWidth-1:0] issued, timeouts;

    // acceptance and completion events; the timeout fires when the count's next value reaches TimeoutCycles-1
    always_comb begin
        accept = (state == ISSUE) && !bus.ga_resp_busy_i;
        tmo    = (state == WAIT || state == DRAIN) && !bus.ga_resp_valid_i && cnt == CntW'(TimeoutCycles - 2);
        done   = bus.ga_resp_valid_i || tmo;
    end

    // state register
    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_n;
    end

    // next-state logic; a flush in WAIT with a same-cycle completion has nothing left to drain
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.instr_valid_i ? ISSUE : IDLE;
            ISSUE:   state_n = accept ? (bus.flush_i ? DRAIN : WAIT) : (bus.flush_i ? IDLE : ISSUE);
            WAIT:    state_n = bus.flush_i ? (done ? IDLE : DRAIN) : (done ? WB : WAIT);
            DRAIN:   state_n = done ? IDLE : DRAIN;
            WB:      state_n = (bus.flush_i || bus.wb_ready_i) ? IDLE : WB;
            default: state_n = IDLE;
        endcase
    end

    // instruction latch, timeout counter, writeback capture and saturating counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {funct, rd, reg_a, reg_b, we, use_ga} <= '0;
            op_a         <= '0;
            op_b         <= '0;
            cnt          <= '0;
            wb_result    <= '0;
            wb_error     <= 1'b0;
            wb_overflow  <= 1'b0;
            wb_underflow <= 1'b0;
            wb_timeout   <= 1'b0;
            issued       <= '0;
            timeouts     <= '0;
        end else begin
            if (state == IDLE && bus.instr_valid_i) begin
                funct  <= bus.instr_funct_i;
                rd     <= bus.instr_rd_i;
                reg_a  <= bus.instr_reg_a_i;
                reg_b  <= bus.instr_reg_b_i;
                we     <= bus.instr_we_i;
                use_ga <= bus.instr_use_ga_regs_i;
                op_a   <= bus.instr_op_a_i;
                op_b   <= bus.instr_op_b_i;
            end
            if (accept) cnt <= '0;
            else if (state == WAIT || state == DRAIN) cnt <= cnt + 1'b1;
            if (accept && issued != '1) issued <= issued + 1'b1;
            if (tmo && timeouts != '1) timeouts <= timeouts + 1'b1;
            if (state == WAIT && !bus.flush_i && done) begin
                wb_result    <= bus.ga_resp_valid_i ? bus.ga_resp_result_i : '0;
                wb_error     <= bus.ga_resp_valid_i ? bus.ga_resp_error_i : 1'b1;
                wb_overflow  <= bus.ga_resp_valid_i && bus.ga_resp_overflow_i;
                wb_underflow <= bus.ga_resp_valid_i && bus.ga_resp_underflow_i;
                wb_timeout   <= !bus.ga_resp_valid_i;
            end
        end
    end

    // outputs decoded from state and registered fields
    always_comb begin
        bus.instr_ready_o        = (state == IDLE) && !rst_i;
        bus.ga_req_valid_o       = (state == ISSUE);
        bus.wb_valid_o           = (state == WB);
        bus.ga_req_funct_o       = funct;
        bus.ga_req_rd_o          = rd;
        bus.ga_req_reg_a_o       = reg_a;
        bus.ga_req_reg_b_o       = reg_b;
        bus.ga_req_we_o          = we;
        bus.ga_req_use_ga_regs_o = use_ga;
        bus.ga_req_op_a_o        = op_a;
        bus.ga_req_op_b_o        = op_b;
        bus.wb_rd_o              = rd;
        bus.wb_we_o              = we;
        bus.wb_result_o          = wb_result;
        bus.wb_error_o           = wb_error;
        bus.wb_overflow_o        = wb_overflow;
        bus.wb_underflow_o       = wb_underflow;
        bus.wb_timeout_o         = wb_timeout;
        bus.perf_issued_o        = issued;
        bus.perf_timeouts_o      = timeouts;
    end
endmodule

// File: tb/tb_ga_issue_unit.sv
// tb_ga_issue_unit: directed checks of issue, backpressure, timeout, flush, reset and counter saturation
module tb_ga_issue_unit;
    localparam int MvW = 1024;
    localparam int PCW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    ga_issue_unit_if #(.MvW(MvW), .PerfCntWidth(PCW)) bus ();

    ga_issue_unit #(
        .DataWidth(32), .NumBlades(32), .TimeoutCycles(16), .PerfCntWidth(PCW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [MvW-1:0] obs, input logic [MvW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic present(input logic [4:0] funct, input logic [4:0] rd, input logic [MvW-1:0] a, input logic [MvW-1:0] b);
        bus.instr_valid_i = 1'b1;
        bus.instr_funct_i = funct;
        bus.instr_rd_i    = rd;
        bus.instr_op_a_i  = a;
        bus.instr_op_b_i  = b;
        tick();
        bus.instr_valid_i = 1'b0;
    endtask

    initial begin
        bus.instr_valid_i = 0; bus.instr_funct_i = 0; bus.instr_rd_i = 0;
        bus.instr_reg_a_i = 5'd7; bus.instr_reg_b_i = 5'd9; bus.instr_use_ga_regs_i = 1'b1;
        bus.instr_we_i = 1'b1; bus.instr_op_a_i = 0; bus.instr_op_b_i = 0; bus.flush_i = 0;
        bus.ga_resp_busy_i = 0; bus.ga_resp_valid_i = 0; bus.ga_resp_result_i = 0;
        bus.ga_resp_error_i = 0; bus.ga_resp_overflow_i = 0; bus.ga_resp_underflow_i = 0;
        bus.wb_ready_i = 0;
        tick(); tick();
        chk("rst_ready", bus.instr_ready_o, 0);
        chk("rst_req_valid", bus.ga_req_valid_o, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_wb_result", bus.wb_result_o, 0);
        chk("rst_perf_issued", bus.perf_issued_o, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", bus.instr_ready_o, 1);

        // basic op
        present(5'd1, 5'd3, 2, 3);
        chk("basic_req_valid", bus.ga_req_valid_o, 1);
        chk("basic_req_rd", bus.ga_req_rd_o, 3);
        chk("basic_req_funct", bus.ga_req_funct_o, 1);
        chk("basic_req_op_b", bus.ga_req_op_b_o, 3);
        chk("basic_req_reg_a", bus.ga_req_reg_a_o, 7);
        chk("basic_ready_low", bus.instr_ready_o, 0);
        tick();
        chk("basic_req_dropped", bus.ga_req_valid_o, 0);
        bus.ga_resp_valid_i = 1; bus.ga_resp_result_i = 5;
        tick();
        bus.ga_resp_valid_i = 0; bus.ga_resp_result_i = 0;
        chk("basic_wb_valid", bus.wb_valid_o, 1);
        chk("basic_wb_rd", bus.wb_rd_o, 3);
        chk("basic_wb_result", bus.wb_result_o, 5);
        chk("basic_wb_error", bus.wb_error_o, 0);
        chk("basic_wb_timeout", bus.wb_timeout_o, 0);
        chk("basic_perf_issued", bus.perf_issued_o, 1);
        bus.wb_ready_i = 1;
        tick();
        bus.wb_ready_i = 0;
        chk("basic_wb_done", bus.wb_valid_o, 0);
        chk("basic_ready_back", bus.instr_ready_o, 1);

        // backpressure on request and writeback
        bus.ga_resp_busy_i = 1;
        present(5'd2, 5'd12, 11, 22);
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", bus.ga_req_valid_o, 1);
            chk("bp_req_rd", bus.ga_req_rd_o, 12);
            chk("bp_req_op_a", bus.ga_req_op_a_o, 11);
            tick();
        end
        bus.ga_resp_busy_i = 0;
        chk("bp_req_valid_5th", bus.ga_req_valid_o, 1);
        tick();
        chk("bp_req_dropped", bus.ga_req_valid_o, 0);
        chk("bp_perf_issued", bus.perf_issued_o, 2);
        bus.ga_resp_valid_i = 1; bus.ga_resp_result_i = 'hAB; bus.ga_resp_overflow_i = 1;
        tick();
        bus.ga_resp_valid_i = 0; bus.ga_resp_result_i = 'hDEAD; bus.ga_resp_overflow_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_valid", bus.wb_valid_o, 1);
            chk("bp_wb_result", bus.wb_result_o, 'hAB);
            chk("bp_wb_overflow", bus.wb_overflow_o, 1);
            chk("bp_wb_rd", bus.wb_rd_o, 12);
            chk("bp_ready_low", bus.instr_ready_o, 0);
            tick();
        end
        bus.wb_ready_i = 1;
        chk("bp_wb_valid_last", bus.wb_valid_o, 1);
        tick();
        bus.wb_ready_i = 0;
        chk("bp_ready_back", bus.instr_ready_o, 1);

        // timeout with no response, then a late response in IDLE
        present(5'd3, 5'd4, 1, 1);
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("to_no_wb_yet", bus.wb_valid_o, 0);
            tick();
        end
        chk("to_wb_valid", bus.wb_valid_o, 1);
        chk("to_wb_error", bus.wb_error_o, 1);
        chk("to_wb_timeout", bus.wb_timeout_o, 1);
        chk("to_wb_result", bus.wb_result_o, 0);
        chk("to_wb_overflow", bus.wb_overflow_o, 0);
        chk("to_perf_timeouts", bus.perf_timeouts_o, 1);
        bus.wb_ready_i = 1;
        tick();
        bus.wb_ready_i = 0;
        bus.ga_resp_valid_i = 1; bus.ga_resp_result_i = 'h99;
        tick();
        bus.ga_resp_valid_i = 0;
        chk("late_no_wb", bus.wb_valid_o, 0);
        chk("late_ready", bus.instr_ready_o, 1);
        chk("late_no_req", bus.ga_req_valid_o, 0);

        // flush during ISSUE while busy
        present(5'd4, 5'd5, 1, 1);
        chk("fi_req_valid", bus.ga_req_valid_o, 1);
        bus.ga_resp_busy_i = 1; bus.flush_i = 1;
        tick();
        bus.ga_resp_busy_i = 0; bus.flush_i = 0;
        chk("fi_req_dropped", bus.ga_req_valid_o, 0);
        chk("fi_ready", bus.instr_ready_o, 1);
        tick();
        chk("fi_no_wb", bus.wb_valid_o, 0);
        chk("fi_perf_issued", bus.perf_issued_o, 3);

        // flush during WAIT, response three cycles later discarded
        present(5'd5, 5'd6, 1, 1);
        tick();
        bus.flush_i = 1;
        tick();
        bus.flush_i = 0;
        chk("fw_drain_ready", bus.instr_ready_o, 0);
        chk("fw_drain_no_wb", bus.wb_valid_o, 0);
        tick(); tick();
        bus.ga_resp_valid_i = 1; bus.ga_resp_result_i = 'h55;
        tick();
        bus.ga_resp_valid_i = 0;
        chk("fw_no_wb", bus.wb_valid_o, 0);
        chk("fw_ready", bus.instr_ready_o, 1);
        chk("fw_result_kept", bus.wb_result_o, 0);
        chk("fw_perf_issued", bus.perf_issued_o, 4);

        // response collides with timeout in the final WAIT cycle
        present(5'd6, 5'd8, 1, 1);
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("col_still_wait", bus.wb_valid_o, 0);
        bus.ga_resp_valid_i = 1; bus.ga_resp_result_i = 'h77; bus.ga_resp_underflow_i = 1;
        tick();
        bus.ga_resp_valid_i = 0; bus.ga_resp_underflow_i = 0;
        chk("col_wb_valid", bus.wb_valid_o, 1);
        chk("col_wb_timeout", bus.wb_timeout_o, 0);
        chk("col_wb_error", bus.wb_error_o, 0);
        chk("col_wb_underflow", bus.wb_underflow_o, 1);
        chk("col_wb_result", bus.wb_result_o, 'h77);
        chk("col_perf_timeouts", bus.perf_timeouts_o, 1);
        chk("col_perf_issued", bus.perf_issued_o, 5);

        // reset while in WB
        rst = 1'b1;
        tick();
        chk("rwb_wb_valid", bus.wb_valid_o, 0);
        chk("rwb_wb_result", bus.wb_result_o, 0);
        chk("rwb_wb_underflow", bus.wb_underflow_o, 0);
        chk("rwb_wb_rd", bus.wb_rd_o, 0);
        chk("rwb_req_valid", bus.ga_req_valid_o, 0);
        chk("rwb_perf_issued", bus.perf_issued_o, 0);
        chk("rwb_perf_timeouts", bus.perf_timeouts_o, 0);
        chk("rwb_ready", bus.instr_ready_o, 0);
        rst = 1'b0;
        #1;
        chk("rwb_idle_ready", bus.instr_ready_o, 1);

        // 2^PCW+2 ops saturate the issued counter
        for (int i = 0; i < (1 << PCW) + 2; i++) begin
            present(5'd1, 5'd2, i, 1);
            tick();
            bus.ga_resp_valid_i = 1; bus.ga_resp_result_i = i;
            tick();
            bus.ga_resp_valid_i = 0;
            chk("sat_wb_result", bus.wb_result_o, i);
            chk("sat_perf_issued", bus.perf_issued_o, (i + 1 < (1 << PCW)) ? i + 1 : (1 << PCW) - 1);
            bus.wb_ready_i = 1;
            tick();
            bus.wb_ready_i = 0;
        end
        chk("sat_final", bus.perf_issued_o, 'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
